mem_write_tracer: RTL and testbench

//  Hardware producer of the data-memory store trace consumed by the pipeline benches. Taps the

---
 rtl/trace_pkg.sv | 14 +
 rtl/trace_fifo.sv | 58 +++++
 rtl/mem_write_tracer.sv | 107 ++++++++++
 tb/tb_mem_write_tracer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the data-memory store tracer.
package trace_pkg;
    localparam int TRACE_DEPTH_DEFAULT = 16;
    localparam int TRACE_AW            = 32;
    localparam int TRACE_DW            = 32;
    localparam int TRACE_CW            = 32;

    // One captured store: address, data and the 1-based cycle it happened in.
    typedef struct packed {
        logic [TRACE_AW-1:0] addr;
        logic [TRACE_DW-1:0] data;
        logic [TRACE_CW-1:0] cycle;
    } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through synchronous FIFO for trace entries.
// Pointers and level reset asynchronously; payload storage is never cleared.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int  DEPTH   = TRACE_DEPTH_DEFAULT,
    parameter type entry_t = trace_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int LW      = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  entry_t        wdata_i,
    output entry_t        rdata_o,
    output logic [LW-1:0] level_o
);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [LW-1:0]   level_q, level_d;
    logic            do_push, do_pop;

    // Guard against popping empty or pushing full without a matching pop.
    always_comb begin
        do_pop  = pop_i & (level_q != '0);
        do_push = push_i & ((level_q != FULL) | do_pop);
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Payload write; no reset so storage stays plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            level_q <= level_d;
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign level_o = level_q;
endmodule

// File: rtl/mem_write_tracer.sv
// Taps the mips data port, tags each store with its cycle number and queues it
// for a valid/ready consumer. Also detects program end and keeps CPI counters.
module mem_write_tracer
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc,
    input  logic [31:0]   pc_finished,
    input  logic          memwrite,
    input  logic [AW-1:0] aluout,
    input  logic [DW-1:0] writedata,
    input  logic          instr_retired,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [AW-1:0] trace_addr,
    output logic [DW-1:0] trace_data,
    output logic [CW-1:0] trace_cycle,
    output logic          finish,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] instr_count,
    output logic          overflow,
    output logic [CW-1:0] drop_count
);
    localparam int            LW   = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] cycle;
    } entry_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic          finish_q, finish_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cycle_q, cycle_d, instr_q, instr_d, drop_q, drop_d;
    logic [LW-1:0] level;
    entry_t        wentry, head;
    logic          done, cap, valid, pop, full, push, drop;

    // Capture / drop decision and counter next-state.
    always_comb begin
        done     = finish_q | (pc == pc_finished);
        cap      = memwrite & ~done;
        valid    = (level != '0);
        pop      = valid & trace_ready;
        full     = (level == FULL);
        push     = cap & (~full | pop);
        drop     = cap & full & ~pop;
        wentry   = '{addr: aluout, data: writedata, cycle: sat_inc(cycle_q)};
        finish_d = done;
        cycle_d  = done ? cycle_q : sat_inc(cycle_q);
        instr_d  = (~done & instr_retired) ? sat_inc(instr_q) : instr_q;
        drop_d   = drop ? sat_inc(drop_q) : drop_q;
        ovf_d    = ovf_q | drop;
    end

    // Status and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            finish_q <= 1'b0;
            ovf_q    <= 1'b0;
            cycle_q  <= '0;
            instr_q  <= '0;
            drop_q   <= '0;
        end else begin
            finish_q <= finish_d;
            ovf_q    <= ovf_d;
            cycle_q  <= cycle_d;
            instr_q  <= instr_d;
            drop_q   <= drop_d;
        end
    end

    trace_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .level_o (level)
    );

    // Head fields read as zero while the queue is empty.
    always_comb begin
        trace_valid = valid;
        trace_addr  = valid ? head.addr  : '0;
        trace_data  = valid ? head.data  : '0;
        trace_cycle = valid ? head.cycle : '0;
    end

    assign finish      = finish_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
    assign overflow    = ovf_q;
    assign drop_count  = drop_q;
endmodule

// File: tb/tb_mem_write_tracer.sv
module tb_mem_write_tracer;
    localparam int DEPTH = 16, AW = 32, DW = 32, CW = 32;
    localparam logic [31:0] PC_END = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc, pc_finished;
    logic          memwrite, instr_retired, trace_ready;
    logic [AW-1:0] aluout;
    logic [DW-1:0] writedata;
    logic          trace_valid, finish, overflow;
    logic [AW-1:0] trace_addr;
    logic [DW-1:0] trace_data;
    logic [CW-1:0] trace_cycle, cycle_count, instr_count, drop_count;

    int tests = 0, fails = 0;

    mem_write_tracer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_finished(pc_finished),
        .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
        .instr_retired(instr_retired), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_cycle(trace_cycle), .finish(finish), .cycle_count(cycle_count),
        .instr_count(instr_count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: queue of stores plus plain counters.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;
    ent_t          mq[$];
    logic [CW-1:0] m_cyc, m_ins, m_drop;
    bit            m_fin, m_ovf;

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1;
    endfunction

    function automatic ent_t head();
        ent_t e;
        if (mq.size() == 0) e = '{'0, '0, '0};
        else e = mq[0];
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cyc = '0; m_ins = '0; m_drop = '0; m_fin = 0; m_ovf = 0;
    endtask

    // Advance one clock; the model applies the store/drain/counter rules.
    task automatic tick();
        bit done, cap, pop;
        int n;
        done = m_fin || (pc == pc_finished);
        cap  = memwrite && !done;
        n    = mq.size();
        pop  = (n != 0) && trace_ready;
        @(posedge clk);
        if (pop) mq.delete(0);
        if (cap) begin
            if (n < DEPTH || pop) mq.push_back('{aluout, writedata, sat(m_cyc)});
            else begin m_drop = sat(m_drop); m_ovf = 1; end
        end
        if (!done) begin
            m_cyc = sat(m_cyc);
            if (instr_retired) m_ins = sat(m_ins);
        end
        else m_fin = 1;
        #1;
    endtask

    task automatic idle_inputs();
        memwrite = 0; instr_retired = 0; trace_ready = 0;
        aluout = '0; writedata = '0; pc = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; model_reset();
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        pc_finished = PC_END;
        reset = 1; model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({trace_valid, finish, overflow, trace_addr, trace_data, trace_cycle,
             cycle_count, instr_count, drop_count} !== '0) begin
            fails++;
            $display("FAIL reset_state: valid=%b fin=%b ovf=%b cyc=%0d ins=%0d drop=%0d, required all 0",
                     trace_valid, finish, overflow, cycle_count, instr_count, drop_count);
        end
        reset = 0;
    endtask

    task automatic test_basic();
        logic [95:0] exp;
        trace_ready = 1;
        for (int k = 1; k <= 7; k++) begin
            memwrite  = (k == 2 || k == 5);
            aluout    = (k == 2) ? 32'h54 : 32'h58;
            writedata = (k == 2) ? 32'h7  : 32'hC;
            tick();
            tests++;
            if (trace_valid !== (k == 2 || k == 5)) begin
                fails++;
                $display("FAIL basic_valid cycle %0d: got %b required %b", k + 1, trace_valid, (k == 2 || k == 5));
            end
            if (k == 2 || k == 5) begin
                exp = (k == 2) ? {32'h54, 32'h7, 32'd2} : {32'h58, 32'hC, 32'd5};
                tests++;
                if ({trace_addr, trace_data, trace_cycle} !== exp) begin
                    fails++;
                    $display("FAIL basic_entry cycle %0d: got %h/%h/%0d required %h", k + 1,
                             trace_addr, trace_data, trace_cycle, exp);
                end
            end
        end
        memwrite = 0;
    endtask

    task automatic test_overflow();
        ent_t e;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            memwrite = 1; aluout = $urandom; writedata = $urandom;
            tick();
        end
        memwrite = 0;
        tests++;
        if (overflow !== 1'b1 || drop_count !== 32'd2 || trace_valid !== 1'b1) begin
            fails++;
            $display("FAIL overflow_flags: ovf=%b drop=%0d valid=%b required 1/2/1", overflow, drop_count, trace_valid);
        end
        trace_ready = 1;
        for (int i = 0; i < 16; i++) begin
            e = head();
            tests++;
            if (trace_valid !== 1'b1 || {trace_addr, trace_data, trace_cycle} !== {e.a, e.d, e.c}
                || e.c !== CW'(i + 1)) begin
                fails++;
                $display("FAIL overflow_drain[%0d]: got %b %h/%h/%0d required 1 %h/%h/%0d",
                         i, trace_valid, trace_addr, trace_data, trace_cycle, e.a, e.d, i + 1);
            end
            tick();
        end
        tests++;
        if (trace_valid !== 1'b0) begin
            fails++;
            $display("FAIL overflow_empty: valid=%b required 0", trace_valid);
        end
        trace_ready = 0;
    endtask

    task automatic test_full_pop();
        ent_t e;
        logic [AW-1:0] last_addr;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            memwrite = 1; aluout = 32'h100 + i; writedata = $urandom;
            tick();
        end
        memwrite = 1; trace_ready = 1; aluout = 32'hBEEF; writedata = 32'h1234;
        tick();
        memwrite = 0;
        tests++;
        if (drop_count !== '0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_pop_drop: drop=%0d ovf=%b required 0/0", drop_count, overflow);
        end
        last_addr = '0;
        for (int i = 0; i < 16; i++) begin
            e = head();
            last_addr = trace_addr;
            tests++;
            if (trace_valid !== 1'b1 || {trace_addr, trace_data, trace_cycle} !== {e.a, e.d, e.c}) begin
                fails++;
                $display("FAIL full_pop_drain[%0d]: got %h/%h/%0d required %h/%h/%0d",
                         i, trace_addr, trace_data, trace_cycle, e.a, e.d, e.c);
            end
            tick();
        end
        tests++;
        if (last_addr !== 32'hBEEF || trace_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_pop_last: last addr %h valid %b required BEEF 0", last_addr, trace_valid);
        end
        trace_ready = 0;
    endtask

    task automatic test_finish();
        ent_t e;
        int guard;
        do_reset();
        for (int k = 1; k <= 39; k++) begin
            pc = k * 4; memwrite = $urandom_range(0, 1);
            aluout = $urandom; writedata = $urandom;
            instr_retired = (k % 4 != 0);
            tick();
        end
        pc = PC_END; memwrite = 1; instr_retired = 1; aluout = 32'hDEAD; writedata = 32'hF00D;
        tick();
        tests++;
        if (finish !== 1'b1 || cycle_count !== 32'd39 || instr_count !== 32'd30) begin
            fails++;
            $display("FAIL finish_counts: fin=%b cyc=%0d ins=%0d required 1/39/30", finish, cycle_count, instr_count);
        end
        pc = 32'h0;
        repeat (3) tick();
        tests++;
        if (finish !== 1'b1 || cycle_count !== 32'd39 || instr_count !== 32'd30) begin
            fails++;
            $display("FAIL finish_frozen: fin=%b cyc=%0d ins=%0d required 1/39/30", finish, cycle_count, instr_count);
        end
        memwrite = 0; instr_retired = 0; trace_ready = 1;
        guard = 0;
        while (mq.size() != 0 && guard < 40) begin
            e = head();
            tests++;
            if (trace_valid !== 1'b1 || {trace_addr, trace_data, trace_cycle} !== {e.a, e.d, e.c}
                || e.a === 32'hDEAD) begin
                fails++;
                $display("FAIL finish_drain: got %b %h/%h/%0d required 1 %h/%h/%0d",
                         trace_valid, trace_addr, trace_data, trace_cycle, e.a, e.d, e.c);
            end
            tick();
            guard++;
        end
        tests++;
        if (trace_valid !== 1'b0 || guard == 0) begin
            fails++;
            $display("FAIL finish_empty: valid=%b pops=%0d required 0 and >0", trace_valid, guard);
        end
        trace_ready = 0;
    endtask

    task automatic test_random();
        ent_t e;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            pc = (k == 350) ? PC_END : 32'h2000 + k;
            memwrite = ($urandom_range(0, 3) != 0);
            trace_ready = ($urandom_range(0, 2) == 0);
            instr_retired = $urandom_range(0, 1);
            aluout = $urandom; writedata = $urandom;
            tick();
            e = head();
            tests++;
            if ({trace_valid, trace_addr, trace_data, trace_cycle, finish, cycle_count, instr_count, overflow, drop_count}
                !== {mq.size() != 0, e.a, e.d, e.c, m_fin, m_cyc, m_ins, m_ovf, m_drop}) begin
                fails++;
                $display("FAIL random[%0d]: got v%b %h/%h/%0d fin%b cyc%0d ins%0d ovf%b drop%0d required v%b %h/%h/%0d fin%b cyc%0d ins%0d ovf%b drop%0d",
                         k, trace_valid, trace_addr, trace_data, trace_cycle, finish, cycle_count, instr_count, overflow, drop_count,
                         mq.size() != 0, e.a, e.d, e.c, m_fin, m_cyc, m_ins, m_ovf, m_drop);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            memwrite = 1; aluout = $urandom; writedata = $urandom; instr_retired = 1;
            tick();
        end
        memwrite = 0;
        tick();
        tests++;
        if (trace_valid !== 1'b1 || mq.size() != 5) begin
            fails++;
            $display("FAIL reset_mid_fill: valid=%b required 1", trace_valid);
        end
        #2 reset = 1;
        #1;
        tests++;
        if ({trace_valid, finish, overflow, trace_addr, trace_data, trace_cycle,
             cycle_count, instr_count, drop_count} !== '0) begin
            fails++;
            $display("FAIL reset_mid_async: valid=%b cyc=%0d ins=%0d required 0/0/0", trace_valid, cycle_count, instr_count);
        end
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        memwrite = 1; aluout = 32'hA0; writedata = 32'h55; instr_retired = 0;
        tick();
        memwrite = 0;
        tests++;
        if (trace_valid !== 1'b1 || trace_cycle !== 32'd1 || trace_addr !== 32'hA0) begin
            fails++;
            $display("FAIL reset_mid_tag: valid=%b cycle=%0d addr=%h required 1/1/a0", trace_valid, trace_cycle, trace_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_finish();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
